fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage of the 16-bit processor, downstream of the program counter. Each fetch reads the word at the PC from instruction memory and latches it into the instruction register. It then hands the instruction to the decoder over a valid/ready handshake. It drives the PC's increment and load strobes, handles branch redirects, and flags memory requests that time out.

## Interface
- AW, 16, address width (matches PC width)
- DW, 16, instruction word width
- TIMEOUT, 15, maximum cycles to wait for mem_ack before declaring a fetch error (4-bit wait counter)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  run enable; fetches start only while high
- pc  in  AW  current PC value (PC register output)
- pc_inc  out  AW? no — 1  PC increment strobe
- pc_ld  out  1  PC load strobe
- pc_in  out  AW  PC load value
- mem_addr  out  AW  instruction memory address
- mem_rd  out  1  memory read request
- mem_rdata  in  DW  memory read data, valid when mem_ack=1
- mem_ack  in  1  one-cycle read acknowledge
- ir  out  DW  instruction register
- ir_pc  out  AW  address the instruction in ir was fetched from
- ir_valid  out  1  ir holds an unconsumed instruction
- ir_ready  in  1  decoder accepts ir this cycle
- redirect  in  1  branch/jump taken
- redirect_addr  in  AW  branch/jump target
- fetch_err  out  1  high while in ERR state

Note: pc_inc is 1 bit wide.

## Operation
- States: IDLE, FETCH, HOLD, ERR. Reset state is IDLE.
- IDLE: mem_rd=0. If en=1, go to FETCH next cycle.
- FETCH: mem_rd=1, mem_addr=pc, both combinational.
  - On mem_ack=1: ir<=mem_rdata, ir_pc<=pc, pc_inc=1 for that cycle only, wait counter<=0, go to HOLD.
  - Otherwise the wait counter increments. When the counter equals TIMEOUT with no ack, go to ERR.
- HOLD: ir_valid=1, mem_rd=0. When ir_valid & ir_ready, the instruction is consumed: go to FETCH if en=1, else IDLE. Without ir_ready, ir and ir_pc stay stable.
- ERR: fetch_err=1, mem_rd=0, ir_valid=0. Exits only on redirect or rst.
- Redirect (any state, highest priority):
  - pc_ld=redirect and pc_in=redirect_addr, both combinational.
  - pc_inc is forced 0 in that cycle, even if mem_ack=1, and mem_rdata is discarded.
  - ir_valid clears on the next edge, and any held instruction is dropped.
  - Next state is FETCH if en=1, else IDLE. The wait counter clears.
- mem_addr = pc in all states. Memory samples the address only in the mem_ack cycle, so changing the address during FETCH is legal.
- en=0 does not abort a fetch already in FETCH. The instruction completes into HOLD, and the unit then parks in IDLE after consumption.

## Timing
- Reset values: state IDLE, ir=0, ir_pc=0, ir_valid=0, mem_rd=0, pc_inc=0, pc_ld=0, fetch_err=0, wait counter=0.
- Asserting rst mid-fetch immediately drops mem_rd and ir_valid.
- With zero-wait memory (mem_ack in the first FETCH cycle) and ir_ready held high, the sequence is FETCH, HOLD, FETCH, and so on: one instruction per 2 cycles.
- ir_valid rises the cycle after the ack. PC shows pc+1 in that same cycle, because pc_inc is sampled by the PC on the ack edge.
- Wrap-around: fetching at 0xFFFF yields ir_pc=0xFFFF and PC=0x0000 next.
- Timeout: with no ack, fetch_err rises the cycle after the counter reaches TIMEOUT. That is after TIMEOUT+1 FETCH cycles, 16 for the default.
- The ack that completes a fetch resets the counter, so the timeout does not accumulate across fetches.

## Test plan
- Reset then en=1, pc=0x0100, memory acks in the first FETCH cycle with 0xA5A5, ir_ready=1:
  - ir=0xA5A5, ir_pc=0x0100, ir_valid for 1 cycle, one pc_inc pulse, PC reaches 0x0101.
  - Sustained rate is 1 instruction per 2 cycles.
- Backpressure: ir_ready=0 for 5 cycles after capture of 0x1234 at 0x0200:
  - ir stays 0x1234 and mem_rd stays 0 throughout.
  - No extra pc_inc.
  - Consumption on the 6th cycle.
- Wait states: mem_ack delayed 3 cycles:
  - mem_rd high for 4 cycles, mem_addr stable at pc.
  - fetch_err stays 0, single pc_inc.
- Redirect to 0x0400 in the same cycle as mem_ack:
  - pc_ld=1, pc_in=0x0400, pc_inc=0, data discarded.
  - Next fetch address is 0x0400, and ir_pc of the next valid instruction is 0x0400.
- No ack for 16 cycles:
  - fetch_err=1, mem_rd=0.
  - Redirect to 0x0000 clears the error and resumes fetching at 0x0000.
- Fetch at 0xFFFF:
  - ir_pc=0xFFFF, PC wraps to 0x0000.
  - Asserting rst mid-FETCH at the next fetch returns all outputs to reset values asynchronously.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads the word at the PC, latches it into the
// instruction register, and hands it to the decoder over a valid/ready
// handshake. Drives the PC increment/load strobes, applies branch redirects
// and flags memory reads that are never acknowledged.
module fetch_unit #(
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic [AW-1:0] i_pc,
    output logic          o_pc_inc,
    output logic          o_pc_ld,
    output logic [AW-1:0] o_pc_in,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_rd,
    input  logic [DW-1:0] i_mem_rdata,
    input  logic          i_mem_ack,
    output logic [DW-1:0] o_ir,
    output logic [AW-1:0] o_ir_pc,
    output logic          o_ir_valid,
    input  logic          i_ir_ready,
    input  logic          i_redirect,
    input  logic [AW-1:0] i_redirect_addr,
    output logic          o_fetch_err
);

    localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TimeoutCnt = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold,
        StErr
    } state_e;

    state_e        r_state;
    logic [CW-1:0] r_wait_cnt;
    logic [DW-1:0] r_ir;
    logic [AW-1:0] r_ir_pc;
    logic          r_ir_valid;
    logic          r_fetch_err;

    // Memory and PC strobes; a redirect suppresses the increment even on an ack.
    always_comb begin
        o_mem_rd   = (r_state == StFetch);
        o_mem_addr = i_pc;
        o_pc_ld    = i_redirect;
        o_pc_in    = i_redirect_addr;
        o_pc_inc   = (r_state == StFetch) && i_mem_ack && !i_redirect;
    end

    assign o_ir        = r_ir;
    assign o_ir_pc     = r_ir_pc;
    assign o_ir_valid  = r_ir_valid;
    assign o_fetch_err = r_fetch_err;

    // Fetch FSM with registered instruction, valid and error outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_wait_cnt  <= '0;
            r_ir        <= '0;
            r_ir_pc     <= '0;
            r_ir_valid  <= 1'b0;
            r_fetch_err <= 1'b0;
        end else if (i_redirect) begin
            // Drop any held instruction and any in-flight read data.
            r_state     <= i_en ? StFetch : StIdle;
            r_wait_cnt  <= '0;
            r_ir_valid  <= 1'b0;
            r_fetch_err <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_en) begin
                        r_state <= StFetch;
                    end
                end
                StFetch: begin
                    if (i_mem_ack) begin
                        r_ir       <= i_mem_rdata;
                        r_ir_pc    <= i_pc;
                        r_wait_cnt <= '0;
                        r_ir_valid <= 1'b1;
                        r_state    <= StHold;
                    end else if (r_wait_cnt == TimeoutCnt) begin
                        r_wait_cnt  <= '0;
                        r_fetch_err <= 1'b1;
                        r_state     <= StErr;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
                end
                StHold: begin
                    if (i_ir_ready) begin
                        r_ir_valid <= 1'b0;
                        r_state    <= i_en ? StFetch : StIdle;
                    end
                end
                StErr: begin
                    // Only a redirect or reset leaves the error state.
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule
